// File: rtl/button_gesture_pkg.sv
// Shared types and helpers for the button gesture classifier.
package button_gesture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG,
        WAIT2,
        PRESS2
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/gesture_timer.sv
// Clearable saturating up-counter; hit flags cnt == limit (limit is the threshold minus one).
module gesture_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != WIDTH'(MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_gesture.sv
// Debounced-button gesture classifier; optional auto-repeat under BUTTON_GESTURE_REPEAT_EN.
// release/repeat are SystemVerilog keywords, so those ports are release_pulse/repeat_pulse.
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int unsigned LONG_CLK_COUNT   = 6000000,
    parameter int unsigned DOUBLE_CLK_COUNT = 3000000,
    parameter int unsigned REPEAT_CLK_COUNT = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic release_pulse,
    output logic short_tap,
    output logic double_tap,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam int unsigned CNT_MAX = max3(LONG_CLK_COUNT, DOUBLE_CLK_COUNT, REPEAT_CLK_COUNT);
`else
    localparam int unsigned CNT_MAX = max3(LONG_CLK_COUNT, DOUBLE_CLK_COUNT, 0);
`endif
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    if (LONG_CLK_COUNT < 2 || DOUBLE_CLK_COUNT < 2 || REPEAT_CLK_COUNT < 2) begin : g_param_check
        $error("button_gesture: all *_CLK_COUNT parameters must be >= 2");
    end

    state_e        state_q, state_d;
    logic          btn_q;
    logic          rise, fall;
    logic          clr, hit;
    logic [CW-1:0] limit;
    logic          press_d, release_d, short_d, double_d, long_d;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    // One shared counter; the active threshold depends on the state.
    always_comb begin
        limit = CW'(LONG_CLK_COUNT - 1);
        case (state_q)
            WAIT2:   limit = CW'(DOUBLE_CLK_COUNT - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
            LONG:    limit = CW'(REPEAT_CLK_COUNT - 1);
`endif
            default: ;
        endcase
    end

    gesture_timer #(
        .WIDTH (CW),
        .MAX   (CNT_MAX)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .limit (limit),
        .hit   (hit)
    );

`ifdef BUTTON_GESTURE_REPEAT_EN
    logic repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    press_d = 1'b1;
                    clr     = 1'b1;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_d   = WAIT2;
                    release_d = 1'b1;
                    clr       = 1'b1;
                end else if (hit && btn) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    clr     = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
`ifdef BUTTON_GESTURE_REPEAT_EN
                end else if (hit && btn) begin
                    repeat_d = 1'b1;
                    clr      = 1'b1;
`endif
                end
            end
            WAIT2: begin
                // A rise on the timeout cycle still counts as a double tap.
                if (rise) begin
                    state_d  = PRESS2;
                    press_d  = 1'b1;
                    double_d = 1'b1;
                end else if (hit) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            btn_q         <= 1'b0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_tap     <= 1'b0;
            double_tap    <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_q         <= btn;
            held          <= btn;
            press         <= press_d;
            release_pulse <= release_d;
            short_tap     <= short_d;
            double_tap    <= double_d;
            long_press    <= long_d;
        end
    end

`ifdef BUTTON_GESTURE_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture: scoreboard of expected pulses keyed by cycle number.
module tb_button_gesture;

    localparam int unsigned LONG = 100;
    localparam int unsigned DBL  = 50;
    localparam int unsigned RPT  = 20;

    localparam logic [5:0] M_PRESS = 6'b100000;
    localparam logic [5:0] M_REL   = 6'b010000;
    localparam logic [5:0] M_SHORT = 6'b001000;
    localparam logic [5:0] M_DBL   = 6'b000100;
    localparam logic [5:0] M_LONG  = 6'b000010;
    localparam logic [5:0] M_RPT   = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic press, release_pulse, short_tap, double_tap, long_press, repeat_pulse, held;

    ev_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    button_gesture #(
        .LONG_CLK_COUNT   (LONG),
        .DOUBLE_CLK_COUNT (DBL),
        .REPEAT_CLK_COUNT (RPT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .press         (press),
        .release_pulse (release_pulse),
        .short_tap     (short_tap),
        .double_tap    (double_tap),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // Pulses registered at posedge number n are compared as cycle n.
    always @(posedge clk) begin : monitor
        logic [5:0] obs;
        logic [5:0] expm;
        #1;
        cyc  = cyc + 1;
        obs  = {press, release_pulse, short_tap, double_tap, long_press, repeat_pulse};
        expm = '0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            if (q[0].cyc == cyc) expm = expm | q[0].mask;
            void'(q.pop_front());
        end
        if (expm != 6'b0 || obs != 6'b0) begin
            total = total + 1;
            if (obs !== expm) begin
                bad = bad + 1;
                $display("FAIL pulses cycle %0d: got %b want %b (press,rel,short,dbl,long,rpt)",
                         cyc, obs, expm);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input int c, input logic [5:0] m);
        int i;
        i = 0;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, '{cyc: c, mask: m});
    endtask

    // Set btn so that posedge number k is the first to sample the new value.
    task automatic drive_at(input int k, input logic v);
        while (cyc < k - 1) @(negedge clk);
        btn = v;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn = 1'b0;
        repeat (10) @(negedge clk);
        total = total + 1;
        if ({press, release_pulse, short_tap, double_tap, long_press, repeat_pulse, held}
            !== 7'b0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {press, release_pulse, short_tap, double_tap, long_press, repeat_pulse,
                      held});
        end
        total = total + 1;
        if (dut.state_q !== button_gesture_pkg::IDLE) begin
            bad = bad + 1;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
    endtask

    task automatic test_reset_release_pressed;
        int e;
        btn = 1'b1;
        rst = 1'b0;
        e = cyc + 1;
        expect_ev(e, M_PRESS);
        expect_ev(e + 5, M_REL);
        expect_ev(e + 5 + DBL, M_SHORT);
        @(negedge clk);
        total = total + 1;
        if (held !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL held_after_reset: got %b want 1", held);
        end
        drive_at(e + 5, 1'b0);
        wait_until(e + 5 + DBL + 5);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL reset_press_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_short_tap;
        int e;
        e = cyc + 2;
        expect_ev(e, M_PRESS);
        expect_ev(e + 10, M_REL);
        expect_ev(e + 10 + DBL, M_SHORT);
        drive_at(e, 1'b1);
        drive_at(e + 10, 1'b0);
        total = total + 1;
        if (held !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL held_high: got %b want 1", held);
        end
        @(negedge clk);
        total = total + 1;
        if (held !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL held_low: got %b want 0", held);
        end
        wait_until(e + 10 + DBL + 5);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL short_tap_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_double_tap;
        int e;
        e = cyc + 2;
        expect_ev(e, M_PRESS);
        expect_ev(e + 10, M_REL);
        expect_ev(e + 30, M_PRESS | M_DBL);
        expect_ev(e + 40, M_REL);
        drive_at(e, 1'b1);
        drive_at(e + 10, 1'b0);
        drive_at(e + 30, 1'b1);
        drive_at(e + 40, 1'b0);
        wait_until(e + 40 + DBL + 10);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL double_tap_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_long_boundary;
        int e;
        e = cyc + 2;
        expect_ev(e, M_PRESS);
        expect_ev(e + LONG, M_REL);
        expect_ev(e + LONG + DBL, M_SHORT);
        drive_at(e, 1'b1);
        drive_at(e + LONG, 1'b0);
        wait_until(e + LONG + DBL + 5);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL long_boundary_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_double_boundary;
        int e;
        e = cyc + 2;
        expect_ev(e, M_PRESS);
        expect_ev(e + 10, M_REL);
        expect_ev(e + 10 + DBL, M_PRESS | M_DBL);
        expect_ev(e + 20 + DBL, M_REL);
        drive_at(e, 1'b1);
        drive_at(e + 10, 1'b0);
        drive_at(e + 10 + DBL, 1'b1);
        drive_at(e + 20 + DBL, 1'b0);
        wait_until(e + 20 + 2 * DBL + 10);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL double_boundary_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_long_hold;
        int e;
        int f;
        e = cyc + 2;
        f = e + 2 * LONG + 1;
        expect_ev(e, M_PRESS);
        expect_ev(e + LONG, M_LONG);
`ifdef BUTTON_GESTURE_REPEAT_EN
        for (int t = e + LONG + RPT; t < f; t += RPT) expect_ev(t, M_RPT);
`endif
        expect_ev(f, M_REL);
        drive_at(e, 1'b1);
        drive_at(f, 1'b0);
        wait_until(f + DBL + 10);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL long_hold_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_reset_abort;
        int e;
        e = cyc + 2;
        expect_ev(e, M_PRESS);
        expect_ev(e + 10, M_REL);
        drive_at(e, 1'b1);
        drive_at(e + 10, 1'b0);
        wait_until(e + 20);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total = total + 1;
        if ({press, release_pulse, short_tap, double_tap, long_press, repeat_pulse, held}
            !== 7'b0) begin
            bad = bad + 1;
            $display("FAIL abort_outputs: got %b want 0000000",
                     {press, release_pulse, short_tap, double_tap, long_press, repeat_pulse,
                      held});
        end
        rst = 1'b0;
        wait_until(e + 10 + 2 * DBL);
        total = total + 1;
        if (dut.state_q !== button_gesture_pkg::IDLE) begin
            bad = bad + 1;
            $display("FAIL abort_state: got %0d want IDLE", dut.state_q);
        end
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL abort_drain: got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_release_pressed();
        test_short_tap();
        test_double_tap();
        test_long_boundary();
        test_double_boundary();
        test_long_hold();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
